sb_rx_decoder: RTL

Sideband receive path of the logical PHY, the far-end counterpart of the sideband transmitter. It captures the forwarded sideband clock/data pins, deserialises 64-bit packets, and moves them into the clk_100MHz domain. It then decodes header packets into SB_msg_t, attaching the 32- or 64-bit payload packet that the message code requires. Decoded messages are presented to the LTSM with a valid/ready handshake.

---
 rtl/SB_codex_pkg.sv | 89 ++++++++
 rtl/sb_rx_capture.sv | 76 +++++++
 rtl/sb_rx_decoder.sv | 133 +++++++++++++
 3 files changed

// File: rtl/SB_codex_pkg.sv
// SB_codex_pkg: sideband message codex shared by the sideband TX and RX paths.
//   SB_msg_t       decoded message identifier (SB_NONE is the all-zero encoding)
//   SB_dec_t       result of decode_SB_msg: msg, expect_32b, expect_64b, ok
//   rx_state_t     receive decoder FSM states
//   encode_SB_msg  message -> 64-bit header word (transmitter side)
//   decode_SB_msg  64-bit header word -> SB_dec_t (inverse of encode_SB_msg)
// Header layout: opcode [4:0], msgcode [21:14], msgsubcode [39:32]; all other bits zero.
package SB_codex_pkg;

    typedef enum logic [3:0] {
        SB_NONE                  = 4'd0,
        SBINIT_OUT_OF_RESET      = 4'd1,
        SBINIT_DONE_REQ          = 4'd2,
        SBINIT_DONE_RESP         = 4'd3,
        MBINIT_PARAM_CONFIG_REQ  = 4'd4,
        MBINIT_PARAM_CONFIG_RESP = 4'd5,
        MEM_WR_32B               = 4'd6
    } SB_msg_t;

    typedef struct packed {
        SB_msg_t msg;
        logic    expect_32b;
        logic    expect_64b;
        logic    ok;
    } SB_dec_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_OUT       = 2'd2
    } rx_state_t;

    localparam logic [4:0]  OP_MSG_NODATA  = 5'b10010;
    localparam logic [4:0]  OP_MSG_64B     = 5'b11011;
    localparam logic [4:0]  OP_MEM_WR_32B  = 5'b00001;
    localparam logic [63:0] HDR_FIELD_MASK = 64'h0000_00FF_003F_C01F;

    function automatic logic [63:0] make_hdr(input logic [4:0] op, input logic [7:0] code,
                                             input logic [7:0] sub);
        logic [63:0] h;
        h        = '0;
        h[4:0]   = op;
        h[21:14] = code;
        h[39:32] = sub;
        return h;
    endfunction

    function automatic logic [63:0] encode_SB_msg(input SB_msg_t msg);
        case (msg)
            SBINIT_OUT_OF_RESET:      return make_hdr(OP_MSG_NODATA, 8'h91, 8'h00);
            SBINIT_DONE_REQ:          return make_hdr(OP_MSG_NODATA, 8'h95, 8'h01);
            SBINIT_DONE_RESP:         return make_hdr(OP_MSG_NODATA, 8'h9A, 8'h01);
            MBINIT_PARAM_CONFIG_REQ:  return make_hdr(OP_MSG_64B, 8'hA5, 8'h00);
            MBINIT_PARAM_CONFIG_RESP: return make_hdr(OP_MSG_64B, 8'hAA, 8'h00);
            MEM_WR_32B:               return make_hdr(OP_MEM_WR_32B, 8'h00, 8'h00);
            default:                  return '0;
        endcase
    endfunction

    function automatic SB_dec_t decode_SB_msg(input logic [63:0] hdr);
        SB_dec_t d;
        d     = '0;
        d.msg = SB_NONE;
        // Any stray bit outside the defined fields makes the header undecodable.
        if ((hdr & ~HDR_FIELD_MASK) == '0) begin
            d.ok = 1'b1;
            case ({hdr[4:0], hdr[21:14], hdr[39:32]})
                {OP_MSG_NODATA, 8'h91, 8'h00}: d.msg = SBINIT_OUT_OF_RESET;
                {OP_MSG_NODATA, 8'h95, 8'h01}: d.msg = SBINIT_DONE_REQ;
                {OP_MSG_NODATA, 8'h9A, 8'h01}: d.msg = SBINIT_DONE_RESP;
                {OP_MSG_64B, 8'hA5, 8'h00}: begin
                    d.msg        = MBINIT_PARAM_CONFIG_REQ;
                    d.expect_64b = 1'b1;
                end
                {OP_MSG_64B, 8'hAA, 8'h00}: begin
                    d.msg        = MBINIT_PARAM_CONFIG_RESP;
                    d.expect_64b = 1'b1;
                end
                {OP_MEM_WR_32B, 8'h00, 8'h00}: begin
                    d.msg        = MEM_WR_32B;
                    d.expect_32b = 1'b1;
                end
                default: d.ok = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/sb_rx_capture.sv
// sb_rx_capture: forwarded-clock half of the sideband receiver.
//   clk_pin    in   gated forwarded sideband clock (64 pulses per packet)
//   data_pin   in   serial data, bit 0 first, sampled on posedge clk_pin
//   reset      in   applied asynchronously here since clk_pin may be stopped
//   rd_gray    in   Gray read pointer from the clk_100MHz domain
//   rd_addr    in   FIFO slot read by the clk_100MHz domain
//   rd_data    out  contents of slot rd_addr
//   wr_gray    out  Gray write pointer, to be synchronised by the reader
//   drop_tog   out  flips each time a completed word is dropped on full
module sb_rx_capture #(
    parameter int fifo_depth = 4,
    localparam int AW = $clog2(fifo_depth),
    localparam int PW = AW + 1
) (
    input  logic          clk_pin,
    input  logic          data_pin,
    input  logic          reset,
    input  logic [PW-1:0] rd_gray,
    input  logic [AW-1:0] rd_addr,
    output logic [63:0]   rd_data,
    output logic [PW-1:0] wr_gray,
    output logic          drop_tog
);

    logic [5:0]    cnt;
    logic [62:0]   shreg;
    logic [PW-1:0] wr_bin, wr_nxt;
    logic [PW-1:0] rd_s1, rd_s2, rd_bin;
    logic          full;
    logic [63:0]   mem [fifo_depth];

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    assign rd_bin  = gray2bin(rd_s2);
    assign wr_nxt  = wr_bin + PW'(1);
    // Binary compare with the wrap bit inverted; equivalent to the Gray full test.
    assign full    = (wr_bin == {~rd_bin[PW-1], rd_bin[PW-2:0]});
    assign rd_data = mem[rd_addr];

    // Reset is released while the link is idle (clock gated low), so the
    // asynchronous deassertion cannot race a clk_pin edge.
    always_ff @(posedge clk_pin or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            shreg    <= '0;
            wr_bin   <= '0;
            wr_gray  <= '0;
            drop_tog <= 1'b0;
            rd_s1    <= '0;
            rd_s2    <= '0;
        end else begin
            rd_s1 <= rd_gray;
            rd_s2 <= rd_s1;
            cnt   <= cnt + 6'd1;
            if (cnt != 6'd63) begin
                shreg[cnt] <= data_pin;
            end else if (full) begin
                drop_tog <= ~drop_tog;
            end else begin
                wr_bin  <= wr_nxt;
                wr_gray <= wr_nxt ^ (wr_nxt >> 1);
            end
        end
    end

    // Storage has no reset; the pointers alone define what is valid.
    always_ff @(posedge clk_pin) begin
        if (cnt == 6'd63 && !full) mem[wr_bin[AW-1:0]] <= {data_pin, shreg};
    end

endmodule

// File: rtl/sb_rx_decoder.sv
// sb_rx_decoder: sideband receive path. Captures forwarded clock/data into a
// small async FIFO, then decodes header (+ optional payload) into SB_msg_t.
//   clk_100MHz, reset  system clock, synchronous active-high reset
//   clkPin_i, dataPin_i  forwarded sideband clock and serial data
//   enable_i    when low, decoded headers are discarded
//   msg_o, dataBus_o, valid_o / ready_i   decoded message handshake to the LTSM
//   error_o     one-cycle pulse on an undecodable header
//   overflow_o  one-cycle pulse when a captured packet was dropped on full
module sb_rx_decoder
    import SB_codex_pkg::*;
#(
    parameter int fifo_depth = 4
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        clkPin_i,
    input  logic        dataPin_i,
    input  logic        enable_i,
    output SB_msg_t     msg_o,
    output logic [63:0] dataBus_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        error_o,
    output logic        overflow_o
);

    localparam int AW = $clog2(fifo_depth);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_gray, wr_s1, wr_s2;
    logic [PW-1:0] rd_bin, rd_gray, rd_nxt;
    logic          drop_tog, tog_s1, tog_s2, tog_q;
    logic [63:0]   word;
    logic          empty;
    logic          expect_32b, expect_64b;
    SB_dec_t       dec;
    rx_state_t     state;

    sb_rx_capture #(.fifo_depth(fifo_depth)) u_capture (
        .clk_pin  (clkPin_i),
        .data_pin (dataPin_i),
        .reset    (reset),
        .rd_gray  (rd_gray),
        .rd_addr  (rd_bin[AW-1:0]),
        .rd_data  (word),
        .wr_gray  (wr_gray),
        .drop_tog (drop_tog)
    );

    assign empty  = (wr_s2 == rd_gray);
    assign rd_nxt = rd_bin + PW'(1);
    assign dec    = decode_SB_msg(word);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            wr_s1      <= '0;
            wr_s2      <= '0;
            tog_s1     <= 1'b0;
            tog_s2     <= 1'b0;
            tog_q      <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            wr_s1      <= wr_gray;
            wr_s2      <= wr_s1;
            tog_s1     <= drop_tog;
            tog_s2     <= tog_s1;
            tog_q      <= tog_s2;
            overflow_o <= tog_s2 ^ tog_q;
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state      <= ST_IDLE;
            rd_bin     <= '0;
            rd_gray    <= '0;
            msg_o      <= SB_NONE;
            dataBus_o  <= '0;
            valid_o    <= 1'b0;
            error_o    <= 1'b0;
            expect_32b <= 1'b0;
            expect_64b <= 1'b0;
        end else begin
            error_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        rd_bin  <= rd_nxt;
                        rd_gray <= rd_nxt ^ (rd_nxt >> 1);
                        if (enable_i) begin
                            if (!dec.ok) begin
                                error_o <= 1'b1;
                            end else if (dec.expect_32b || dec.expect_64b) begin
                                msg_o      <= dec.msg;
                                expect_32b <= dec.expect_32b;
                                expect_64b <= dec.expect_64b;
                                state      <= ST_WAIT_DATA;
                            end else begin
                                msg_o     <= dec.msg;
                                dataBus_o <= '0;
                                valid_o   <= 1'b1;
                                state     <= ST_OUT;
                            end
                        end
                    end
                end
                // The payload is taken raw, never run through the header decoder.
                ST_WAIT_DATA: begin
                    if (!empty) begin
                        rd_bin  <= rd_nxt;
                        rd_gray <= rd_nxt ^ (rd_nxt >> 1);
                        if (expect_64b)      dataBus_o <= word;
                        else if (expect_32b) dataBus_o <= {32'd0, word[31:0]};
                        else                 dataBus_o <= '0;
                        valid_o <= 1'b1;
                        state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
